// File: rtl/tape_transport.sv
// Cassette transport controller: tape length / head position, play, FF, REW, stop sequencing.
// Optional build macro TAPE_LOOP_EN: PLAY wraps to position 0 at end of tape instead of stopping.
module tape_transport #(
    parameter int POS_W    = 24,
    parameter int DIV_MAX  = 6666,
    parameter int FAST_DIV = 415,
    parameter int FF_STEP  = 16
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             cmd_play,
    input  logic             cmd_stop,
    input  logic             cmd_ff,
    input  logic             cmd_rew,
    input  logic             len_we,
    input  logic [POS_W-1:0] len,
    output logic [POS_W-1:0] max,
    output logic [POS_W-1:0] pos,
    output logic             ena,
    output logic             motor,
    output logic [2:0]       state,
    output logic             at_end
);

    // state | meaning
    // EMPTY | no tape loaded, commands ignored
    // STOP  | tape loaded, motor off
    // PLAY  | pos +1 every DIV_MAX+1 clocks
    // FF    | pos +FF_STEP every FAST_DIV+1 clocks
    // REW   | pos -FF_STEP every FAST_DIV+1 clocks
    typedef enum logic [2:0] {
        ST_EMPTY = 3'd0,
        ST_STOP  = 3'd1,
        ST_PLAY  = 3'd2,
        ST_FF    = 3'd3,
        ST_REW   = 3'd4
    } state_t;

    localparam int DIV_TOP = (DIV_MAX > FAST_DIV) ? DIV_MAX : FAST_DIV;
    localparam int DIV_W   = (DIV_TOP < 1) ? 1 : $clog2(DIV_TOP + 1);
    localparam int PW1     = POS_W + 1;
    localparam logic [PW1-1:0]   STEP_X = PW1'(FF_STEP);
    localparam logic [POS_W-1:0] STEP_N = POS_W'(FF_STEP);

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d, max_q, max_d;
    logic [DIV_W-1:0]   div_q, div_d, term;
    logic               ena_q, ena_d, motor_q, motor_d, at_end_q, at_end_d;
    logic               motion, tick, boundary;
    logic [PW1-1:0]     ff_sum;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        max_d    = max_q;
        div_d    = '0;
        at_end_d = 1'b0;
        boundary = 1'b0;
        ff_sum   = {1'b0, pos_q} + STEP_X;
        motion   = (state_q == ST_PLAY) || (state_q == ST_FF) || (state_q == ST_REW);
        term     = (state_q == ST_PLAY) ? DIV_W'(DIV_MAX) : DIV_W'(FAST_DIV);
        tick     = motion && (div_q == term);

        // Tick position update first; a command on the same cycle sees the updated pos.
        if (tick) begin
            case (state_q)
                ST_PLAY: begin
                    if (({1'b0, pos_q} + PW1'(1)) < {1'b0, max_q}) begin
                        pos_d = pos_q + POS_W'(1);
                    end else begin
                        at_end_d = 1'b1;
`ifdef TAPE_LOOP_EN
                        pos_d    = '0;
`else
                        pos_d    = max_q;
                        boundary = 1'b1;
`endif
                    end
                end
                ST_FF: begin
                    if (ff_sum >= {1'b0, max_q}) begin
                        pos_d    = max_q;
                        at_end_d = 1'b1;
                        boundary = 1'b1;
                    end else begin
                        pos_d = ff_sum[POS_W-1:0];
                    end
                end
                ST_REW: begin
                    if ({1'b0, pos_q} <= STEP_X) begin
                        pos_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        pos_d = pos_q - STEP_N;
                    end
                end
                default: ;
            endcase
        end

        if (state_q != ST_EMPTY) begin
            if (boundary || cmd_stop) begin
                state_d = ST_STOP;
            end else if (cmd_rew && (pos_d != '0)) begin
                state_d = ST_REW;
            end else if (cmd_ff && (pos_d != max_q)) begin
                state_d = ST_FF;
            end else if (cmd_play && (pos_d != max_q)) begin
                state_d = ST_PLAY;
            end
        end

        // Loading a tape aborts everything, including a coincident end-of-tape event.
        if (len_we) begin
            max_d    = len;
            pos_d    = '0;
            at_end_d = 1'b0;
            state_d  = (len != '0) ? ST_STOP : ST_EMPTY;
        end

        if (state_d == state_q && motion) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end

        ena_d   = (state_d != ST_EMPTY);
        motor_d = (state_d == ST_PLAY) || (state_d == ST_FF) || (state_d == ST_REW);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_EMPTY;
            pos_q    <= '0;
            max_q    <= '0;
            div_q    <= '0;
            ena_q    <= 1'b0;
            motor_q  <= 1'b0;
            at_end_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            max_q    <= max_d;
            div_q    <= div_d;
            ena_q    <= ena_d;
            motor_q  <= motor_d;
            at_end_q <= at_end_d;
        end
    end

    assign state  = state_q;
    assign pos    = pos_q;
    assign max    = max_q;
    assign ena    = ena_q;
    assign motor  = motor_q;
    assign at_end = at_end_q;

endmodule

// File: tb/tb_tape_transport.sv
// Directed bench for tape_transport with DIV_MAX=3, FAST_DIV=1, FF_STEP=4.
module tb_tape_transport;

    localparam int POS_W = 8;

    logic             clk_sys = 1'b0;
    logic             reset_n;
    logic             cmd_play, cmd_stop, cmd_ff, cmd_rew, len_we;
    logic [POS_W-1:0] len;
    logic [POS_W-1:0] max_w, pos_w;
    logic             ena_w, motor_w, at_end_w;
    logic [2:0]       state_w;

    int total  = 0;
    int passed = 0;

    tape_transport #(.POS_W(POS_W), .DIV_MAX(3), .FAST_DIV(1), .FF_STEP(4)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .cmd_play(cmd_play),
        .cmd_stop(cmd_stop),
        .cmd_ff  (cmd_ff),
        .cmd_rew (cmd_rew),
        .len_we  (len_we),
        .len     (len),
        .max     (max_w),
        .pos     (pos_w),
        .ena     (ena_w),
        .motor   (motor_w),
        .state   (state_w),
        .at_end  (at_end_w)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic cmd(input logic p, input logic s, input logic f, input logic r);
        cmd_play = p; cmd_stop = s; cmd_ff = f; cmd_rew = r;
        edges(1);
        cmd_play = 0; cmd_stop = 0; cmd_ff = 0; cmd_rew = 0;
    endtask

    task automatic load(input logic [POS_W-1:0] l);
        len = l; len_we = 1;
        edges(1);
        len_we = 0;
    endtask

    initial begin
        reset_n = 0; cmd_play = 0; cmd_stop = 0; cmd_ff = 0; cmd_rew = 0; len_we = 0; len = '0;
        #12;
        chk("rst_state", state_w, 0);
        chk("rst_pos", pos_w, 0);
        chk("rst_max", max_w, 0);
        chk("rst_ena", ena_w, 0);
        chk("rst_motor", motor_w, 0);
        chk("rst_at_end", at_end_w, 0);
        @(negedge clk_sys);
        reset_n = 1;
        edges(1);

        load(10);
        chk("load_state", state_w, 1);
        chk("load_max", max_w, 10);
        chk("load_pos", pos_w, 0);
        chk("load_ena", ena_w, 1);
        chk("load_motor", motor_w, 0);

        cmd(1, 0, 0, 0);
        chk("play_state", state_w, 2);
        chk("play_motor", motor_w, 1);
        edges(3);
        chk("play_pos_pre", pos_w, 0);
        edges(1);
        chk("play_pos1", pos_w, 1);
        edges(4);
        chk("play_pos2", pos_w, 2);

        cmd(1, 0, 1, 0);
        chk("ff_over_play", state_w, 3);
        chk("ff_pos_entry", pos_w, 2);
        edges(2);
        chk("ff_pos6", pos_w, 6);
        edges(2);
        chk("ff_pos_sat", pos_w, 10);
        chk("ff_at_end", at_end_w, 1);
        chk("ff_stop", state_w, 1);
        edges(1);
        chk("ff_at_end_off", at_end_w, 0);

        cmd(0, 0, 0, 1);
        chk("rew_state", state_w, 4);
        edges(2);
        chk("rew_pos6", pos_w, 6);
        edges(2);
        chk("rew_pos2", pos_w, 2);
        edges(2);
        chk("rew_pos0", pos_w, 0);
        chk("rew_stop", state_w, 1);
        chk("rew_no_at_end", at_end_w, 0);
        cmd(0, 0, 0, 1);
        chk("rew_at_zero_ignored", state_w, 1);

        cmd(1, 0, 0, 0);
        edges(36);
        chk("play_pos9", pos_w, 9);
        edges(4);
        chk("end_at_end", at_end_w, 1);
`ifdef TAPE_LOOP_EN
        chk("end_pos_loop", pos_w, 0);
        chk("end_state_loop", state_w, 2);
`else
        chk("end_pos", pos_w, 10);
        chk("end_state", state_w, 1);
`endif
        edges(1);
        chk("end_at_end_off", at_end_w, 0);
        cmd(0, 1, 0, 0);
        chk("stop_state", state_w, 1);
`ifndef TAPE_LOOP_EN
        cmd(1, 0, 0, 0);
        chk("play_at_max_ignored", state_w, 1);
        cmd(0, 0, 1, 0);
        chk("ff_at_max_ignored", state_w, 1);
`endif

        load(10);
        cmd(1, 1, 0, 0);
        chk("stop_over_play", state_w, 1);
        chk("stop_over_play_motor", motor_w, 0);
        cmd(1, 0, 0, 0);
        edges(20);
        chk("play_pos5", pos_w, 5);
        cmd_play = 1;
        load(20);
        cmd_play = 0;
        chk("reload_pos", pos_w, 0);
        chk("reload_max", max_w, 20);
        chk("reload_state", state_w, 1);
        chk("reload_motor", motor_w, 0);
        load(0);
        chk("empty_state", state_w, 0);
        chk("empty_ena", ena_w, 0);
        chk("empty_max", max_w, 0);
        cmd(1, 0, 0, 0);
        chk("empty_play_ignored", state_w, 0);
        cmd(0, 0, 1, 1);
        chk("empty_ffrew_ignored", state_w, 0);

        load(10);
        cmd(1, 0, 0, 0);
        edges(3);
        cmd(0, 0, 1, 0);
        chk("tick_cmd_pos", pos_w, 1);
        chk("tick_cmd_state", state_w, 3);
        edges(2);
        chk("ff_from1_pos5", pos_w, 5);
        #3;
        reset_n = 0;
        #2;
        chk("async_state", state_w, 0);
        chk("async_pos", pos_w, 0);
        chk("async_max", max_w, 0);
        chk("async_ena", ena_w, 0);
        chk("async_motor", motor_w, 0);
        chk("async_at_end", at_end_w, 0);
        @(negedge clk_sys);
        reset_n = 1;
        edges(3);
        chk("post_rst_state", state_w, 0);
        cmd(1, 0, 0, 0);
        chk("post_rst_play_ignored", state_w, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
